// File: rtl/param_bank_pkg.sv
// Shared types and helpers for the parameter bank: dump FSM states and the
// index-width derivation used by the top level.
package param_bank_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } dump_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_bank.sv
// Bank of NUM_VALUES registers with overridable reset contents, a lockable
// write port, a registered read port and a valid/ready dump engine.
module param_bank
    import param_bank_pkg::*;
#(
    parameter int                          NUM_VALUES  = 2,
    parameter int                          WIDTH       = 32,
    parameter logic [NUM_VALUES*WIDTH-1:0] INIT_VALUES = {32'd9, 32'd5},
    parameter int                          IDX_W       = idx_width(NUM_VALUES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_lock,
    output logic             wr_err,
    output logic             locked,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [IDX_W-1:0] dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_last
);

    localparam logic [IDX_W:0]   NUM_V    = (IDX_W + 1)'(NUM_VALUES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

    logic [NUM_VALUES-1:0][WIDTH-1:0] mem_q;
    logic                             locked_q;
    logic                             wr_err_q;
    logic [WIDTH-1:0]                 rd_data_q;

    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;

    assign wr_in_range = ({1'b0, wr_idx} < NUM_V);
    assign rd_in_range = ({1'b0, rd_idx} < NUM_V);
    assign wr_ok       = wr_en && !locked_q && wr_in_range;

    // Lock is sampled before this edge's wr_lock, so a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= INIT_VALUES;
            locked_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_idx] <= wr_data;
            end
            if (wr_lock) begin
                locked_q <= 1'b1;
            end
            wr_err_q  <= wr_en && !wr_ok;
            rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
        end
    end

    assign wr_err  = wr_err_q;
    assign locked  = locked_q;
    assign rd_data = rd_data_q;

    dump_state_e      state_q, state_d;
    logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic [WIDTH-1:0] beat_data_q, beat_data_d;
    logic             beat_last_q, beat_last_d;
    logic [IDX_W-1:0] next_idx;

    assign next_idx = beat_idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (dump_start) state_d = SEND;
            SEND: if (dump_ready && beat_last_q) state_d = IDLE;
        endcase
    end

    always_comb begin
        dump_busy  = (state_q == SEND);
        dump_valid = (state_q == SEND);
    end

    // Beat payload is captured from storage on load, so later writes do not
    // disturb a beat that is being held under backpressure.
    always_comb begin
        beat_idx_d  = beat_idx_q;
        beat_data_d = beat_data_q;
        beat_last_d = beat_last_q;
        if (state_q == IDLE && dump_start) begin
            beat_idx_d  = '0;
            beat_data_d = mem_q[0];
            beat_last_d = (NUM_VALUES == 1);
        end else if (state_q == SEND && dump_ready) begin
            if (beat_last_q) begin
                beat_idx_d  = '0;
                beat_data_d = '0;
                beat_last_d = 1'b0;
            end else begin
                beat_idx_d  = next_idx;
                beat_data_d = mem_q[next_idx];
                beat_last_d = (next_idx == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx_q  <= '0;
            beat_data_q <= '0;
            beat_last_q <= 1'b0;
        end else begin
            beat_idx_q  <= beat_idx_d;
            beat_data_q <= beat_data_d;
            beat_last_q <= beat_last_d;
        end
    end

    assign dump_idx  = beat_idx_q;
    assign dump_data = beat_data_q;
    assign dump_last = beat_last_q;

endmodule

// File: tb/tb_param_bank.sv
// Bench for param_bank: directed checks on default/overridden 2x32 banks and a
// 3x8 bank, plus a model-checked randomized run on a 4x8 bank.
module tb_param_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 2x32 banks: default contents and defparam-overridden contents, shared inputs
    logic        a_rst = 1'b1, a_wr_en = 1'b0, a_wr_lock = 1'b0;
    logic        a_dump_start = 1'b0, a_dump_ready = 1'b0;
    logic [0:0]  a_wr_idx = '0, a_rd_idx = '0;
    logic [31:0] a_wr_data = '0;

    logic        d_wr_err, d_locked, d_dump_busy, d_dump_valid, d_dump_last;
    logic [0:0]  d_dump_idx;
    logic [31:0] d_rd_data, d_dump_data;
    logic        o_wr_err, o_locked, o_dump_busy, o_dump_valid, o_dump_last;
    logic [0:0]  o_dump_idx;
    logic [31:0] o_rd_data, o_dump_data;

    param_bank u_def (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_data(a_wr_data),
        .wr_lock(a_wr_lock), .wr_err(d_wr_err), .locked(d_locked), .rd_idx(a_rd_idx),
        .rd_data(d_rd_data), .dump_start(a_dump_start), .dump_busy(d_dump_busy),
        .dump_valid(d_dump_valid), .dump_ready(a_dump_ready), .dump_idx(d_dump_idx),
        .dump_data(d_dump_data), .dump_last(d_dump_last)
    );

    param_bank u_ovr (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_data(a_wr_data),
        .wr_lock(a_wr_lock), .wr_err(o_wr_err), .locked(o_locked), .rd_idx(a_rd_idx),
        .rd_data(o_rd_data), .dump_start(a_dump_start), .dump_busy(o_dump_busy),
        .dump_valid(o_dump_valid), .dump_ready(a_dump_ready), .dump_idx(o_dump_idx),
        .dump_data(o_dump_data), .dump_last(o_dump_last)
    );
    defparam u_ovr.INIT_VALUES = {32'd33, 32'd32};

    // 3x8 bank: index range is not a power of two, so out-of-range is reachable
    logic       c_wr_en = 1'b0;
    logic [1:0] c_wr_idx = '0, c_rd_idx = '0;
    logic [7:0] c_wr_data = '0;
    logic       c_wr_err, c_locked, c_dump_busy, c_dump_valid, c_dump_last;
    logic [1:0] c_dump_idx;
    logic [7:0] c_rd_data, c_dump_data;

    param_bank #(.NUM_VALUES(3), .WIDTH(8), .INIT_VALUES({8'h03, 8'h02, 8'h01})) u_c (
        .clk(clk), .rst(a_rst), .wr_en(c_wr_en), .wr_idx(c_wr_idx), .wr_data(c_wr_data),
        .wr_lock(1'b0), .wr_err(c_wr_err), .locked(c_locked), .rd_idx(c_rd_idx),
        .rd_data(c_rd_data), .dump_start(1'b0), .dump_busy(c_dump_busy),
        .dump_valid(c_dump_valid), .dump_ready(1'b1), .dump_idx(c_dump_idx),
        .dump_data(c_dump_data), .dump_last(c_dump_last)
    );

    // 4x8 bank under model-checked stimulus
    localparam logic [31:0] B_INIT = {8'h44, 8'h33, 8'h22, 8'h11};

    logic       b_rst = 1'b1, b_wr_en = 1'b0, b_wr_lock = 1'b0;
    logic       b_dump_start = 1'b0, b_dump_ready = 1'b0;
    logic [1:0] b_wr_idx = '0, b_rd_idx = '0;
    logic [7:0] b_wr_data = '0;
    logic       b_wr_err, b_locked, b_dump_busy, b_dump_valid, b_dump_last;
    logic [1:0] b_dump_idx;
    logic [7:0] b_rd_data, b_dump_data;

    param_bank #(.NUM_VALUES(4), .WIDTH(8), .INIT_VALUES(B_INIT)) u_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_data(b_wr_data),
        .wr_lock(b_wr_lock), .wr_err(b_wr_err), .locked(b_locked), .rd_idx(b_rd_idx),
        .rd_data(b_rd_data), .dump_start(b_dump_start), .dump_busy(b_dump_busy),
        .dump_valid(b_dump_valid), .dump_ready(b_dump_ready), .dump_idx(b_dump_idx),
        .dump_data(b_dump_data), .dump_last(b_dump_last)
    );

    // Reference model: array contents, lock flag and the beat currently on offer
    bit [7:0] m_mem [4];
    bit       m_lock, m_busy, m_last, e_err;
    bit [1:0] m_idx;
    bit [7:0] m_data, e_rd;
    logic [1:0] hs_q [$];

    task automatic b_step(input bit rst_v, input bit wen, input bit [1:0] widx,
                          input bit [7:0] wdata, input bit lk, input bit [1:0] ridx,
                          input bit st, input bit rdy);
        b_rst = rst_v; b_wr_en = wen; b_wr_idx = widx; b_wr_data = wdata;
        b_wr_lock = lk; b_rd_idx = ridx; b_dump_start = st; b_dump_ready = rdy;
        if (!rst_v && b_dump_valid && rdy) hs_q.push_back(b_dump_idx);
        if (rst_v) begin
            for (int i = 0; i < 4; i++) m_mem[i] = B_INIT[i*8 +: 8];
            m_lock = 0; m_busy = 0; e_err = 0; e_rd = 0;
            m_idx = 0; m_data = 0; m_last = 0;
        end else begin
            e_err = wen && m_lock;
            e_rd  = m_mem[ridx];
            if (!m_busy) begin
                if (st) begin
                    m_busy = 1; m_idx = 0; m_data = m_mem[0]; m_last = 0;
                end
            end else if (rdy) begin
                if (m_idx == 2'd3) m_busy = 0;
                else begin
                    m_idx  = m_idx + 2'd1;
                    m_data = m_mem[m_idx];
                    m_last = (m_idx == 2'd3);
                end
            end
            if (wen && !m_lock) m_mem[widx] = wdata;
            if (lk) m_lock = 1;
        end
        tick();
        chk("b_wr_err", b_wr_err, e_err);
        chk("b_locked", b_locked, m_lock);
        chk("b_rd_data", b_rd_data, e_rd);
        chk("b_busy", b_dump_busy, m_busy);
        chk("b_valid", b_dump_valid, m_busy);
        if (m_busy || rst_v) begin
            chk("b_dump_idx", b_dump_idx, m_idx);
            chk("b_dump_data", b_dump_data, m_data);
            chk("b_dump_last", b_dump_last, m_last);
        end
    endtask

    initial begin
        int          busy_cnt;
        logic [1:0]  bi [$];
        logic [31:0] bd [$];
        logic        bl [$];

        // ---- 2x32 banks: reset state and override ----
        tick();
        a_rst = 1'b0;
        chk("d_reset_outs", {d_locked, d_wr_err, d_rd_data, d_dump_busy, d_dump_valid,
                             d_dump_idx, d_dump_data, d_dump_last}, '0);
        chk("o_reset_outs", {o_locked, o_wr_err, o_rd_data, o_dump_busy, o_dump_valid,
                             o_dump_idx, o_dump_data, o_dump_last}, '0);
        chk("c_reset_outs", {c_locked, c_wr_err, c_rd_data, c_dump_busy, c_dump_valid,
                             c_dump_idx, c_dump_data, c_dump_last}, '0);
        a_rd_idx = 1'b1;
        tick();
        chk("ovr_rd1", o_rd_data, 32'd33);
        chk("def_rd1", d_rd_data, 32'd9);
        a_rd_idx = 1'b0;
        tick();
        chk("ovr_rd0", o_rd_data, 32'd32);
        chk("def_rd0", d_rd_data, 32'd5);

        // ---- default dump, ready high ----
        a_dump_ready = 1'b1;
        a_dump_start = 1'b1;
        tick();
        a_dump_start = 1'b0;
        busy_cnt = 0;
        repeat (5) begin
            if (d_dump_busy) busy_cnt++;
            if (d_dump_valid) begin
                bi.push_back(d_dump_idx); bd.push_back(d_dump_data); bl.push_back(d_dump_last);
            end
            tick();
        end
        chk("def_busy_cycles", busy_cnt, 2);
        chk("def_beats", bi.size(), 2);
        if (bi.size() == 2) begin
            chk("def_beat0", {bi[0], bd[0], bl[0]}, {1'b0, 32'd5, 1'b0});
            chk("def_beat1", {bi[1], bd[1], bl[1]}, {1'b1, 32'd9, 1'b1});
        end

        // ---- write with lock in the same cycle, then a locked write ----
        a_wr_en = 1'b1; a_wr_idx = 1'b0; a_wr_data = 32'hA5; a_wr_lock = 1'b1;
        tick();
        chk("lock_set", d_locked, 1'b1);
        chk("lock_wr_ok", d_wr_err, 1'b0);
        a_wr_idx = 1'b1; a_wr_data = 32'h11; a_wr_lock = 1'b0; a_rd_idx = 1'b0;
        tick();
        chk("locked_wr_err", d_wr_err, 1'b1);
        chk("lock_cycle_wr_landed", d_rd_data, 32'hA5);
        a_wr_en = 1'b0; a_rd_idx = 1'b1;
        tick();
        chk("err_pulse_one_cycle", d_wr_err, 1'b0);
        chk("locked_val1_kept", d_rd_data, 32'd9);

        // ---- 3x8 bank: out-of-range write and read ----
        c_wr_en = 1'b1; c_wr_idx = 2'd3; c_wr_data = 8'hFF; c_rd_idx = 2'd3;
        tick();
        chk("c_oor_wr_err", c_wr_err, 1'b1);
        chk("c_oor_rd", c_rd_data, 8'h00);
        c_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_rd_idx = 2'(i);
            tick();
            chk("c_rd_unchanged", c_rd_data, 8'(i + 1));
        end

        // ---- 4x8 bank: backpressure while the held beat's source is written ----
        b_step(1, 0, 0, 0, 0, 0, 0, 0);
        b_step(0, 0, 0, 0, 0, 0, 1, 1);
        b_step(0, 0, 0, 0, 0, 0, 0, 1);
        b_step(0, 1, 1, 8'h7E, 0, 1, 0, 0);
        chk("bp_hold0", b_dump_data, 8'h22);
        b_step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("bp_hold1", b_dump_data, 8'h22);
        b_step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("bp_hold2", {b_dump_idx, b_dump_data}, {2'd1, 8'h22});
        chk("bp_wr_landed", b_rd_data, 8'h7E);
        repeat (4) b_step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("bp_done", b_dump_busy, 1'b0);

        // ---- start collisions: mid-dump and on the last-beat cycle ----
        hs_q.delete();
        b_step(0, 0, 0, 0, 0, 0, 1, 1);
        b_step(0, 0, 0, 0, 0, 0, 1, 1);
        repeat (6) b_step(0, 0, 0, 0, 0, 0, b_dump_valid && b_dump_last, 1);
        chk("coll_beats", hs_q.size(), 4);
        if (hs_q.size() == 4) begin
            chk("coll_first_idx", hs_q[0], 2'd0);
            chk("coll_last_idx", hs_q[3], 2'd3);
        end
        chk("coll_idle", b_dump_busy, 1'b0);

        // ---- reset mid-dump ----
        b_step(0, 1, 2, 8'h5A, 0, 0, 0, 0);
        b_step(0, 0, 0, 0, 0, 0, 1, 1);
        b_step(0, 0, 0, 0, 0, 0, 0, 1);
        b_step(1, 0, 0, 0, 0, 0, 0, 1);
        b_step(0, 0, 0, 0, 0, 2, 1, 0);
        chk("rst_restart", {b_dump_idx, b_dump_data}, {2'd0, 8'h11});
        chk("rst_revert", b_rd_data, 8'h33);
        b_step(0, 0, 0, 0, 0, 0, 0, 1);

        // ---- randomized traffic ----
        repeat (400) begin
            b_step($urandom_range(49) == 0, $urandom_range(1) == 1, 2'($urandom_range(3)),
                   8'($urandom), $urandom_range(39) == 0, 2'($urandom_range(3)),
                   $urandom_range(7) == 0, $urandom_range(3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
